acl2_spi_seq: RTL and testbench

Hardware transaction sequencer for the PmodACL2 (ADXL362) accelerometer. It drives the modified simple-SPI core's register-side strobes directly, with no Picoblaze involvement: it frames chip-select, pushes command, address and data bytes, and pops the returned bytes. Register read/write bursts are issued from a simple start/done request port, so a sampling engine can poll the accelerometer without firmware.

---
 rtl/acl2_pkg.sv | 8 +
 rtl/acl2_cs_timer.sv | 16 +
 rtl/acl2_spi_seq.sv | 112 +++++++++++
 tb/tb_acl2_spi_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acl2_pkg.sv
// acl2_pkg: shared constants and state encoding for the ADXL362 SPI transaction sequencer
package acl2_pkg;
  localparam logic [7:0] ADXL362_CMD_RD = 8'h0B;
  localparam logic [7:0] ADXL362_CMD_WR = 8'h0A;
  localparam int SPSR_RFEMPTY = 0;
  localparam int SPSR_WFEMPTY = 2;
  typedef enum logic [2:0] {IDLE, FLUSH, SETUP, PUSH, WAIT, POP, HOLD, DONE} state_t;
endpackage

// File: rtl/acl2_cs_timer.sv
// acl2_cs_timer: loadable down-counter timing the chip-select setup and hold phases
// Ports: clk, reset (sync, active-high), load/load_val (restart count), zero (count reached 0)
module acl2_cs_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= 8'd0;
    else if (load) cnt <= load_val;
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  assign zero = cnt == 8'd0;
endmodule

// File: rtl/acl2_spi_seq.sv
// acl2_spi_seq: ADXL362 register read/write burst sequencer driving the simple-SPI core strobes
// Request side: start, rd_nwr, reg_addr, byte_cnt, wr_data -> wr_data_req, rd_data, rd_valid, busy, done, err
// SPI core side: wfwe/wfdin push, rfre/rfdout pop, spsr status; ncs_o is the accelerometer chip select
// Optional macro ACL2_SEQ_TIMEOUT_EN enables the per-wait watchdog driving err.
module acl2_spi_seq
  import acl2_pkg::*;
#(
  parameter int CS_SETUP_CYC = 4,
  parameter int CS_HOLD_CYC  = 4,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rd_nwr,
  input  logic [7:0] reg_addr,
  input  logic [3:0] byte_cnt,
  input  logic [7:0] wr_data,
  output logic       wr_data_req,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       wfwe,
  output logic [7:0] wfdin,
  output logic       rfre,
  input  logic [7:0] rfdout,
  input  logic [7:0] spsr,
  output logic       ncs_o
);
  state_t state, nxt;
  logic rd_l, half, t_zero, t_load, to, rf_empty, data_byte;
  logic [7:0] addr_l, t_val;
  logic [4:0] total, idx;
  logic unused_bits;
  assign rf_empty = spsr[SPSR_RFEMPTY];
  assign data_byte = idx >= 5'd2;
  assign unused_bits = ^{spsr[7:1], 16'(TIMEOUT_CYC)};
  // A timer load happens on entry to SETUP/HOLD and at the HOLD midpoint (ncs rises)
  assign t_load = (nxt == SETUP && state != SETUP) || (nxt == HOLD && state != HOLD) ||
                  (state == HOLD && t_zero && !half);
  assign t_val = (nxt == SETUP) ? 8'(CS_SETUP_CYC - 1) : 8'(CS_HOLD_CYC - 1);
  acl2_cs_timer u_timer (
    .clk(clk), .reset(reset), .load(t_load), .load_val(t_val), .zero(t_zero)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = !start ? IDLE : (byte_cnt == 4'd0) ? DONE : FLUSH;
      FLUSH: nxt = to ? HOLD : rf_empty ? SETUP : FLUSH;
      SETUP: nxt = t_zero ? PUSH : SETUP;
      PUSH:  nxt = WAIT;
      WAIT:  nxt = to ? HOLD : !rf_empty ? POP : WAIT;
      POP:   nxt = (idx + 5'd1 == total) ? HOLD : PUSH;
      HOLD:  nxt = (t_zero && half) ? DONE : HOLD;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    ncs_o = !(state inside {SETUP, PUSH, WAIT, POP} || (state == HOLD && !half));
    wfwe = state == PUSH;
    wfdin = (state != PUSH) ? 8'h00 :
            (idx == 5'd0) ? (rd_l ? ADXL362_CMD_RD : ADXL362_CMD_WR) :
            (idx == 5'd1) ? addr_l :
            rd_l ? 8'h00 : wr_data;
    wr_data_req = state == PUSH && !rd_l && data_byte;
    rfre = (state == FLUSH && !rf_empty) || state == POP;
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      rd_l <= 1'b0;
      addr_l <= 8'h00;
      total <= 5'd0;
      idx <= 5'd0;
      half <= 1'b0;
      rd_data <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= state == POP && rd_l && data_byte;
      if (state == POP && rd_l && data_byte) rd_data <= rfdout;
      if (state == IDLE && start) begin
        rd_l <= rd_nwr;
        addr_l <= reg_addr;
        total <= {1'b0, byte_cnt} + 5'd2;
        idx <= 5'd0;
      end else if (state == POP) idx <= idx + 5'd1;
      half <= state == HOLD && (half || t_zero);
    end
`ifdef ACL2_SEQ_TIMEOUT_EN
  logic [15:0] tcnt;
  assign to = (state == FLUSH || state == WAIT) && tcnt == 16'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    if (reset) begin
      tcnt <= 16'd0;
      err <= 1'b0;
    end else begin
      tcnt <= ((state == FLUSH || state == WAIT) && !to) ? tcnt + 16'd1 : 16'd0;
      if (state == IDLE && start) err <= 1'b0;
      else if (to) err <= 1'b1;
    end
`else
  assign to = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_acl2_spi_seq.sv
// tb_acl2_spi_seq: scoreboard bench for acl2_spi_seq with a behavioural SPI core read-FIFO model
module tb_acl2_spi_seq;
  logic clk = 0, reset = 1, start = 0, rd_nwr = 0;
  logic [7:0] reg_addr = 0;
  logic [3:0] byte_cnt = 0;
  logic [7:0] wr_data, rd_data, wfdin, rfdout, spsr;
  logic wr_data_req, rd_valid, busy, done, err, wfwe, rfre, ncs_o;
  always #5 clk = ~clk;

  acl2_spi_seq dut (
    .clk(clk), .reset(reset), .start(start), .rd_nwr(rd_nwr), .reg_addr(reg_addr),
    .byte_cnt(byte_cnt), .wr_data(wr_data), .wr_data_req(wr_data_req), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .err(err), .wfwe(wfwe), .wfdin(wfdin),
    .rfre(rfre), .rfdout(rfdout), .spsr(spsr), .ncs_o(ncs_o)
  );

  int tests = 0, fails = 0;
  int push_seen = 0, done_seen = 0, wrq_seen = 0, rdv_seen = 0, rfre_hi = 0, ncs_fall = 0;
  int wr_idx = 0;
  logic ncs_prev = 1'b1;
  logic [7:0] exp_push[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wr_tab[16] = '{8'h02, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  assign wr_data = wr_tab[wr_idx[3:0]];

  // SPI core model: each pushed byte returns miso_base+n (n = byte index in transaction)
  // three cycles later, unless stall holds it back.
  logic [7:0] mem[4];
  logic [1:0] rp = 0, wp = 0, pend_cnt = 0;
  logic [2:0] cnt = 0;
  logic [7:0] pend_byte = 0, miso_base = 0, resp_n = 0, inj_byte = 0;
  logic stall = 0, inj = 0, arrive, push_en, pop_en;
  assign rfdout = mem[rp];
  assign spsr = {5'b0, 1'b1, 1'b0, cnt == 3'd0};
  assign arrive = pend_cnt == 2'd1 && !stall;
  assign push_en = arrive || inj;
  assign pop_en = rfre && cnt != 3'd0;
  always @(posedge clk) begin
    if (pop_en) rp <= rp + 2'd1;
    if (push_en) begin
      mem[wp] <= inj ? inj_byte : pend_byte;
      wp <= wp + 2'd1;
    end
    cnt <= cnt + 3'(push_en) - 3'(pop_en);
    if (wfwe) begin
      pend_cnt <= 2'd3;
      pend_byte <= miso_base + resp_n;
      resp_n <= resp_n + 8'd1;
    end else begin
      if (pend_cnt > 2'd1 || arrive) pend_cnt <= pend_cnt - 2'd1;
      if (!busy) resp_n <= 8'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (wfwe) begin
        push_seen++;
        check("ncs_low_at_push", 32'(ncs_o), 32'd0);
        if (exp_push.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL push_unexpected: got %0h, expected no push", wfdin);
        end else check("push_byte", 32'(wfdin), 32'(exp_push.pop_front()));
      end
      if (wr_data_req) begin
        wrq_seen++;
        wr_idx++;
      end
      if (rd_valid) begin
        rdv_seen++;
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_unexpected: got %0h, expected no rd_valid", rd_data);
        end else check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
      end
      if (done) done_seen++;
      if (rfre && ncs_o) rfre_hi++;
      if (!ncs_o && ncs_prev) ncs_fall++;
    end
    ncs_prev = ncs_o;
  end

  task automatic req(input logic rd, input logic [7:0] a, input logic [3:0] n);
    @(negedge clk);
    rd_nwr = rd;
    reg_addr = a;
    byte_cnt = n;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int bound);
    int target = done_seen + 1;
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = done_seen >= target;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, expected done within %0d cycles", bound);
    end
  endtask

  task automatic wait_push(input int bound);
    int target = push_seen + 1;
    bit ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      ok = push_seen >= target;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got no push, expected push within %0d cycles", bound);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, w0, r0, f0, h0;
    repeat (3) @(negedge clk);
    check("rst_ncs", 32'(ncs_o), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wfwe", 32'(wfwe), 32'd0);
    check("rst_rfre", 32'(rfre), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_wr_data_req", 32'(wr_data_req), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wfdin", 32'(wfdin), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 0;
    repeat (2) @(negedge clk);

    // single-byte read of register 0x00, data byte returns 0xAD
    miso_base = 8'hAB;
    exp_push = '{8'h0B, 8'h00, 8'h00};
    exp_rd = '{8'hAD};
    d0 = done_seen; r0 = rdv_seen; f0 = ncs_fall; h0 = rfre_hi;
    req(1, 8'h00, 4'd1);
    wait_done(500);
    repeat (10) @(negedge clk);
    check("rd1_done_count", 32'(done_seen - d0), 32'd1);
    check("rd1_rd_valid_count", 32'(rdv_seen - r0), 32'd1);
    check("rd1_ncs_falls", 32'(ncs_fall - f0), 32'd1);
    check("rd1_flush_pops", 32'(rfre_hi - h0), 32'd0);
    check("rd1_ncs_idle", 32'(ncs_o), 32'd1);

    // write burst 0x02, 0x00 to POWER_CTL (0x2D)
    exp_push = '{8'h0A, 8'h2D, 8'h02, 8'h00};
    d0 = done_seen; r0 = rdv_seen; w0 = wrq_seen;
    req(0, 8'h2D, 4'd2);
    wait_done(500);
    repeat (10) @(negedge clk);
    check("wr_done_count", 32'(done_seen - d0), 32'd1);
    check("wr_req_count", 32'(wrq_seen - w0), 32'd2);
    check("wr_rd_valid_count", 32'(rdv_seen - r0), 32'd0);

    // three-byte read burst from 0x0E: data bytes return base+2..base+4
    miso_base = 8'h40;
    exp_push = '{8'h0B, 8'h0E, 8'h00, 8'h00, 8'h00};
    exp_rd = '{8'h42, 8'h43, 8'h44};
    r0 = rdv_seen;
    req(1, 8'h0E, 4'd3);
    wait_done(1000);
    repeat (10) @(negedge clk);
    check("rd3_rd_valid_count", 32'(rdv_seen - r0), 32'd3);

    // null request: done the very next cycle, no chip-select activity
    d0 = done_seen; f0 = ncs_fall;
    req(1, 8'h00, 4'd0);
    check("null_done_next", 32'(done), 32'd1);
    @(negedge clk);
    check("null_done_pulse", 32'(done), 32'd0);
    check("null_busy_after", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("null_done_count", 32'(done_seen - d0), 32'd1);
    check("null_ncs_falls", 32'(ncs_fall - f0), 32'd0);

    // start while busy (stuck in WAIT) is ignored
    miso_base = 8'h50;
    exp_push = '{8'h0B, 8'h02, 8'h00};
    exp_rd = '{8'h52};
    stall = 1;
    d0 = done_seen;
    req(1, 8'h02, 4'd1);
    wait_push(200);
    repeat (4) @(negedge clk);
    check("busy_in_wait", 32'(busy), 32'd1);
    req(0, 8'h77, 4'd5);
    stall = 0;
    wait_done(500);
    repeat (40) @(negedge clk);
    check("busy_done_count", 32'(done_seen - d0), 32'd1);
    check("busy_push_left", 32'(exp_push.size()), 32'd0);

    // stale read FIFO: two preloaded bytes are flushed with ncs high
    @(negedge clk);
    inj = 1; inj_byte = 8'hE1;
    @(negedge clk);
    inj_byte = 8'hE2;
    @(negedge clk);
    inj = 0;
    miso_base = 8'h10;
    exp_push = '{8'h0B, 8'h0E, 8'h00};
    exp_rd = '{8'h12};
    h0 = rfre_hi; f0 = ncs_fall;
    req(1, 8'h0E, 4'd1);
    wait_done(500);
    repeat (5) @(negedge clk);
    check("stale_flush_pops", 32'(rfre_hi - h0), 32'd2);
    check("stale_ncs_falls", 32'(ncs_fall - f0), 32'd1);

    // reset while waiting in WAIT, then a clean read
    stall = 1;
    exp_push = '{8'h0A, 8'h1F, 8'h5A};
    req(0, 8'h1F, 4'd1);
    wait_push(200);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check("midrst_ncs", 32'(ncs_o), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    reset = 0;
    exp_push.delete();
    stall = 0;
    repeat (6) @(negedge clk);
    miso_base = 8'h30;
    exp_push = '{8'h0B, 8'h08, 8'h00, 8'h00};
    exp_rd = '{8'h32, 8'h33};
    h0 = rfre_hi; r0 = rdv_seen;
    req(1, 8'h08, 4'd2);
    wait_done(800);
    repeat (5) @(negedge clk);
    check("postrst_flush_pops", 32'(rfre_hi - h0), 32'd1);
    check("postrst_rd_valid_count", 32'(rdv_seen - r0), 32'd2);
    check("postrst_push_left", 32'(exp_push.size()), 32'd0);

`ifdef ACL2_SEQ_TIMEOUT_EN
    // watchdog: a reply that never arrives sets err and the transaction still ends
    stall = 1;
    exp_push = '{8'h0B, 8'h00};
    req(1, 8'h00, 4'd1);
    wait_done(6000);
    check("to_err", 32'(err), 32'd1);
    repeat (2) @(negedge clk);
    check("to_ncs_high", 32'(ncs_o), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    exp_push.delete();
    stall = 0;
    repeat (6) @(negedge clk);
`else
    check("no_timeout_err", 32'(err), 32'd0);
`endif

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
